// File: rtl/load_store_unit_if.sv
// Request/response and data-memory port bundle for load_store_unit.
// master = execute stage plus memory side, slave = the LSU itself.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);
  // Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1.
  // req_ready is high only while the unit is idle; done pulses for one cycle per request.
  logic                  req_valid;
  logic                  req_ready;
  logic                  we;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  done;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, we, funct3, addr, wdata, mem_rdata,
    input  req_ready, rdata, done, fault, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, we, funct3, addr, wdata, mem_rdata,
    output req_ready, rdata, done, fault, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store formatter for a 64-bit word memory without byte enables; sub-word stores are read-modify-write.
// Optional macro LSU_ALIGN_CHECK_EN: fault misaligned H/W/D instead of clearing the low address bits.
module load_store_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic               i_clk,
  input  logic               i_arst,
  load_store_unit_if.slave   bus,
  output logic [1:0]         state_dbg
);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [2:0]            low_mask;
  logic                  illegal_f3;
  logic                  misaligned;
  logic                  req_fault;
  logic [ADDR_WIDTH-1:0] acc_addr;

  always_comb begin
    low_mask   = 3'b000;
    illegal_f3 = bus.we ? bus.funct3[2] : (bus.funct3 == 3'b111);
    case (bus.funct3[1:0])
      2'b00:   low_mask = 3'b000;
      2'b01:   low_mask = 3'b001;
      2'b10:   low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = |(bus.addr[2:0] & low_mask);
    acc_addr   = bus.addr;
`else
    // Without the check, the access is pulled down to its natural boundary.
    misaligned = 1'b0;
    acc_addr   = bus.addr & ~{{(ADDR_WIDTH-3){1'b0}}, low_mask};
`endif
    req_fault  = illegal_f3 | misaligned;
  end

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_val;

  always_comb begin
    shifted  = bus.mem_rdata >> {addr_q[2:0], 3'b000};
    load_val = '0;
    case (funct3_q)
      3'b000:  load_val = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'b011:  load_val = shifted;
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      3'b110:  load_val = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: load_val = '0;
    endcase
  end

  logic [NB-1:0]         byte_base;
  logic [NB-1:0]         byte_mask;
  logic [DATA_WIDTH-1:0] wshift;
  logic [DATA_WIDTH-1:0] merged;

  // Byte lanes covered by the store take the shifted store data; the rest keep the word just read.
  always_comb begin
    byte_base = '0;
    case (funct3_q[1:0])
      2'b00:   byte_base = NB'(8'h01);
      2'b01:   byte_base = NB'(8'h03);
      2'b10:   byte_base = NB'(8'h0F);
      default: byte_base = NB'(8'hFF);
    endcase
    byte_mask = byte_base << addr_q[2:0];
    wshift    = wdata_q << {addr_q[2:0], 3'b000};
    merged    = '0;
    for (int i = 0; i < NB; i++) begin
      merged[8*i +: 8] = byte_mask[i] ? wshift[8*i +: 8] : bus.mem_rdata[8*i +: 8];
    end
  end

  logic is_sd;
  assign is_sd = we_q & (funct3_q == 3'b011);

  // Memory strobes decode straight from state so an async reset kills a pending write at once.
  assign bus.mem_we    = (state == WRITE) | ((state == ACCESS) & is_sd);
  assign bus.mem_wdata = (state == WRITE) ? merge_q :
                         ((state == ACCESS) & is_sd) ? wdata_q : '0;
  assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
  assign bus.req_ready = (state == IDLE);
  assign bus.done      = (state == RESP);
  assign bus.fault     = (state == RESP) & fault_q;
  assign bus.rdata     = rdata_q;
  assign state_dbg     = state;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state    <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      merge_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= acc_addr;
            funct3_q <= bus.funct3;
            we_q     <= bus.we;
            wdata_q  <= bus.wdata;
            fault_q  <= req_fault;
            rdata_q  <= '0;
            state    <= req_fault ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_val;
            state   <= RESP;
          end else if (is_sd) begin
            state   <= RESP;
          end else begin
            merge_q <= merged;
            state   <= WRITE;
          end
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level reference memory model.
// Honors LSU_ALIGN_CHECK_EN so it matches whichever build of the design it is compiled with.
module tb_load_store_unit;
  logic       clk = 1'b0;
  logic       arst;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  bit         finished = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) bus ();

  load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut (
    .i_clk     (clk),
    .i_arst    (arst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Data memory: combinational read, write on the clock edge.
  logic [63:0] mem [0:127];
  logic [63:0] ref_mem [0:127];
  assign bus.mem_rdata = mem[bus.mem_addr[9:3]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:3]] <= bus.mem_wdata;

  typedef struct {
    int          acc_cyc;
    int          done_cyc;
    int          we_cyc;
    logic [9:0]  waddr;
    logic [63:0] wword;
    logic [63:0] rdata;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: byte-wise view of the memory word; commits stores to ref_mem immediately.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                                input logic [63:0] wd, output exp_t e, output int lat);
    int          size;
    int          off;
    logic [9:0]  eff;
    bit          bad;
    logic [63:0] word;
    logic [63:0] val;
    size = 1 << f3[1:0];
    bad  = we ? f3[2] : (f3 == 3'b111);
`ifdef LSU_ALIGN_CHECK_EN
    if (int'(addr) % size != 0) bad = 1'b1;
    eff = addr;
`else
    eff = 10'(int'(addr) / size * size);
`endif
    e = '{acc_cyc: 0, done_cyc: 0, we_cyc: -1, waddr: '0, wword: '0, rdata: '0, fault: 1'b0};
    if (bad) begin
      e.fault = 1'b1;
      lat = 1;
      return;
    end
    word = ref_mem[eff[9:3]];
    off  = int'(eff[2:0]);
    if (!we) begin
      val = '0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = word[8*(off+i) +: 8];
      if (!f3[2] && size < 8 && val[8*size-1]) for (int b = 8*size; b < 64; b++) val[b] = 1'b1;
      e.rdata = val;
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      ref_mem[eff[9:3]] = word;
      e.wword = word;
      e.waddr = {eff[9:3], 3'b000};
      lat = (size == 8) ? 2 : 3;
    end
  endfunction

  // pin_kind: 0 none, 1 model load result, 2 model write word, 3 model fault
  task automatic issue(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                       input logic [63:0] wd, input int pin_kind, input logic [63:0] pin_val,
                       input int pin_lat, input string pin_name);
    exp_t e;
    int   lat;
    int   waited;
    @(negedge clk);
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 64'(bus.req_ready), 64'd1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.we        = we;
    bus.funct3    = f3;
    bus.addr      = addr;
    bus.wdata     = wd;
    model(we, f3, addr, wd, e, lat);
    e.acc_cyc  = cyc;
    e.done_cyc = cyc + lat;
    if (we && !e.fault) e.we_cyc = cyc + lat - 1;
    exp_q.push_back(e);
    case (pin_kind)
      1: chk({pin_name, "_model_rdata"}, e.rdata, pin_val);
      2: chk({pin_name, "_model_wword"}, e.wword, pin_val);
      3: chk({pin_name, "_model_fault"}, 64'(e.fault), pin_val);
      default: ;
    endcase
    if (pin_kind != 0) chk({pin_name, "_model_lat"}, 64'(lat), 64'(pin_lat));
    @(posedge clk);
    // While busy, wiggle the request lines; none of it may be accepted.
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus.req_valid = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.we        = 1'($urandom_range(0, 1));
      bus.funct3    = 3'($urandom_range(0, 7));
      bus.addr      = 10'($urandom_range(0, 1023));
      bus.wdata     = {$urandom, $urandom};
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Compare process: every cycle, handshake, strobes and response against the model timeline.
  always @(negedge clk) begin
    if (chk_en && !arst) begin
      bit   have;
      exp_t e;
      have = (exp_q.size() != 0);
      if (have) e = exp_q[0];
      chk("req_ready", 64'(bus.req_ready), 64'(!have || cyc == e.acc_cyc));
      chk("done",      64'(bus.done),      64'(have && cyc == e.done_cyc));
      chk("mem_we",    64'(bus.mem_we),    64'(have && cyc == e.we_cyc));
      if (have && cyc == e.we_cyc) begin
        chk("mem_wdata", bus.mem_wdata, e.wword);
        chk("mem_addr",  64'(bus.mem_addr), 64'(e.waddr));
      end
      if (have && cyc == e.done_cyc) begin
        chk("fault", 64'(bus.fault), 64'(e.fault));
        chk("rdata", bus.rdata, e.rdata);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500us;
    if (!finished) begin
      errors++;
      $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    logic [63:0] w;
    arst          = 1'b1;
    bus.req_valid = 1'b0;
    bus.we        = 1'b0;
    bus.funct3    = 3'b000;
    bus.addr      = '0;
    bus.wdata     = '0;
    for (int i = 0; i < 128; i++) begin
      w = {$urandom, $urandom};
      mem[i] = w;
      ref_mem[i] = w;
    end
    mem[8]     = 64'h8877665544332211;
    ref_mem[8] = 64'h8877665544332211;

    repeat (3) @(negedge clk);
    chk("rst_ready",     64'(bus.req_ready), 64'd1);
    chk("rst_done",      64'(bus.done),      64'd0);
    chk("rst_fault",     64'(bus.fault),     64'd0);
    chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
    chk("rst_rdata",     bus.rdata,          64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("rst_mem_wdata", bus.mem_wdata,      64'd0);
    arst   = 1'b0;
    chk_en = 1'b1;

    issue(1'b0, 3'b000, 10'h047, 64'd0, 1, 64'hFFFFFFFFFFFFFF88, 2, "lb_047");
    issue(1'b0, 3'b100, 10'h047, 64'd0, 1, 64'h0000000000000088, 2, "lbu_047");
    issue(1'b0, 3'b010, 10'h044, 64'd0, 1, 64'hFFFFFFFF88776655, 2, "lw_044");
    issue(1'b0, 3'b110, 10'h044, 64'd0, 1, 64'h0000000088776655, 2, "lwu_044");
    issue(1'b0, 3'b011, 10'h040, 64'd0, 1, 64'h8877665544332211, 2, "ld_040");
`ifdef LSU_ALIGN_CHECK_EN
    issue(1'b0, 3'b001, 10'h043, 64'd0, 3, 64'd1, 1, "lh_043");
`else
    issue(1'b0, 3'b001, 10'h043, 64'd0, 1, 64'h0000000000004433, 2, "lh_043");
`endif
    issue(1'b1, 3'b001, 10'h042, 64'h000000001234BEEF, 2, 64'h88776655BEEF2211, 3, "sh_042");
    issue(1'b1, 3'b011, 10'h048, 64'hDEADBEEFCAFEF00D, 2, 64'hDEADBEEFCAFEF00D, 2, "sd_048");
    issue(1'b1, 3'b100, 10'h050, 64'd5, 3, 64'd1, 1, "sbu_illegal");
    issue(1'b0, 3'b111, 10'h050, 64'd0, 3, 64'd1, 1, "ld111_illegal");

    // Reset during the write phase of an SB: the write must never reach memory.
    wait_empty();
    chk_en = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.we        = 1'b1;
    bus.funct3    = 3'b000;
    bus.addr      = 10'h051;
    bus.wdata     = 64'h00000000000000A5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre_we", 64'(bus.mem_we), 64'd1);
    #2 arst = 1'b1;
    #1;
    chk("rst_mid_we",    64'(bus.mem_we),    64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid_done",  64'(bus.done),      64'd0);
    @(negedge clk);
    arst = 1'b0;
    chk("rst_mid_word", mem[10], ref_mem[10]);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_done", 64'(bus.done), 64'd0);
    end
    chk_en = 1'b1;
    issue(1'b0, 3'b011, 10'h048, 64'd0, 1, 64'hDEADBEEFCAFEF00D, 2, "ld_after_rst");

    for (int n = 0; n < 300; n++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 127));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom},
            0, 64'd0, 0, "rnd");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    wait_empty();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);
    end
    chk("final_mem_word8", mem[8], ref_mem[8]);
    finished = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
